// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer_if
// Description : Execute-stage <-> RV32M sequencer handshake bundle. The
//               master side is the execute stage, the slave side is the
//               multi-cycle multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, op_a, op_b, flush,
    input  stall, busy, result_valid, result
  );

  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output stall, busy, result_valid, result
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Multi-cycle RV32M controller. Radix-2 shift-add multiply and
//               restoring divide on operand magnitudes, one step per cycle,
//               with sign fixup on the last step. Divide-by-zero and signed
//               overflow finish in one cycle. Optional macro
//               MULDIV_FAST_MUL_EN makes all multiplies single-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  C_ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  C_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_funct3;
  logic              r_neg;
  logic [XLEN-1:0]   r_opnd;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] r_acc;      // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0]   r_result;

  logic              w_stall;
  logic              w_rvalid;

  // ---------------------------------------------------------------- decode
  logic              w_sgn_a;
  logic              w_sgn_b;
  logic              w_neg_a;
  logic              w_neg_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_neg_init;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_fast_mul;
  logic [XLEN-1:0]   w_fast_res;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic              w_accept;

  assign w_sgn_a = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
                   (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
  assign w_sgn_b = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) ||
                   (bus.funct3 == 3'd6);
  assign w_neg_a = w_sgn_a & bus.op_a[XLEN-1];
  assign w_neg_b = w_sgn_b & bus.op_b[XLEN-1];
  assign w_mag_a = w_neg_a ? -bus.op_a : bus.op_a;
  assign w_mag_b = w_neg_b ? -bus.op_b : bus.op_b;

  // Remainder takes the dividend sign; product and quotient take the XOR.
  assign w_neg_init = (bus.funct3[2] && bus.funct3[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);

  assign w_div_zero = bus.funct3[2] && (bus.op_b == '0);
  assign w_div_ovf  = ((bus.funct3 == 3'd4) || (bus.funct3 == 3'd6)) &&
                      (bus.op_a == C_INT_MIN) && (bus.op_b == C_ALL_ONES);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_a;
  logic [2*XLEN-1:0] w_fast_b;
  logic [2*XLEN-1:0] w_fast_prod;

  // Sign/zero extension to 64 bits lets one unsigned multiplier cover all four ops.
  assign w_fast_a    = {{XLEN{w_neg_a}}, bus.op_a};
  assign w_fast_b    = {{XLEN{w_neg_b}}, bus.op_b};
  assign w_fast_prod = w_fast_a * w_fast_b;
  assign w_fast_mul  = !bus.funct3[2];
  assign w_fast_res  = (bus.funct3 == 3'd0) ? w_fast_prod[XLEN-1:0]
                                            : w_fast_prod[2*XLEN-1:XLEN];
`else
  assign w_fast_mul  = 1'b0;
  assign w_fast_res  = '0;
`endif

  assign w_special = w_div_zero | w_div_ovf | w_fast_mul;
  assign w_special_res = w_div_zero ? (bus.funct3[1] ? bus.op_a : C_ALL_ONES) :
                         w_div_ovf  ? (bus.funct3[1] ? '0 : C_INT_MIN) :
                                      w_fast_res;
  assign w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;

  // ----------------------------------------------------------- iteration step
  logic [XLEN:0]     w_add;
  logic [2*XLEN-1:0] w_mul_nxt;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [2*XLEN-1:0] w_div_nxt;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_fix;
  logic              w_last;

  assign w_add     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
  assign w_mul_nxt = r_acc[0] ? {w_add, r_acc[XLEN-1:1]}
                              : {1'b0, r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1:1]};

  // Shifted partial remainder is XLEN+1 bits; the difference always fits XLEN.
  assign w_ge      = r_acc[2*XLEN-1:XLEN-1] >= {1'b0, r_opnd};
  assign w_diff    = r_acc[2*XLEN-2:XLEN-1] - r_opnd;
  assign w_div_nxt = w_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1}
                          : {r_acc[2*XLEN-2:0], 1'b0};

  assign w_acc_nxt  = r_funct3[2] ? w_div_nxt : w_mul_nxt;
  assign w_prod_fix = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_quo_fix  = r_neg ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
  assign w_rem_fix  = r_neg ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
  assign w_last     = (r_cnt == C_CNT_LAST);

  // Select the final signed/unsigned result from the last step's accumulator.
  always_comb begin
    w_fix = '0;
    case (r_funct3)
      3'd0:    w_fix = w_prod_fix[XLEN-1:0];
      3'd1,
      3'd2,
      3'd3:    w_fix = w_prod_fix[2*XLEN-1:XLEN];
      3'd4:    w_fix = w_quo_fix;
      3'd5:    w_fix = w_acc_nxt[XLEN-1:0];
      3'd6:    w_fix = w_rem_fix;
      default: w_fix = w_acc_nxt[2*XLEN-1:XLEN];
    endcase
  end

  // ---------------------------------------------------------------- FSM
  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, stall and completion pulse; flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_rvalid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_stall     = 1'b1;
          w_state_nxt = w_special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        w_stall = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_rvalid    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
      w_stall     = 1'b0;
      w_rvalid    = 1'b0;
    end
  end

  // Operand latch on accept, one radix-2 step per CALC cycle, result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_neg    <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_funct3 <= bus.funct3;
      r_cnt    <= '0;
      r_neg    <= w_neg_init;
      if (w_special) begin
        r_result <= w_special_res;
      end else begin
        r_opnd <= bus.funct3[2] ? w_mag_b : w_mag_a;
        r_acc  <= {{XLEN{1'b0}}, (bus.funct3[2] ? w_mag_a : w_mag_b)};
      end
    end else if ((r_state == S_CALC) && !bus.flush) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) r_result <= w_fix;
    end
  end

  assign bus.stall        = w_stall;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.result_valid = w_rvalid;
  assign bus.result       = r_result;

endmodule
`default_nettype wire
